// File: rtl/fu_gemm_seq_pkg.sv
// fu_gemm_seq_pkg -- datapath types shared by the GEMM sequencer and the
// tensor-core pipeline.
//   gemm_instr_t : one queued GEMM instruction (register indices + reload flag)
//   gemm_state_t : sequencer FSM states
//   req_kind_t   : row request kind driven towards the array / register file
// Register fields are sized for the widest register file in use
// (GEMM_REG_W_MAX); a block with a narrower REG_W zero-extends on entry and
// uses only the low REG_W bits.
package fu_gemm_seq_pkg;

   localparam int GEMM_REG_W_MAX = 8;

   typedef logic [GEMM_REG_W_MAX-1:0] gemm_reg_t;

   typedef struct packed {
      gemm_reg_t rs1;         // input matrix register
      gemm_reg_t rs2;         // weight matrix register
      gemm_reg_t rs3;         // partial-sum matrix register
      gemm_reg_t rd;          // destination register
      logic      new_weight;  // force weight reload even if rs2 matches
   } gemm_instr_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_W = 2'd1,
      STREAM = 2'd2,
      WB     = 2'd3
   } gemm_state_t;

   typedef enum logic {
      REQ_WEIGHT = 1'b0,
      REQ_INPUT  = 1'b1
   } req_kind_t;

endpackage

// File: rtl/fu_gemm_seq_fifo.sv
// gemm_instr_fifo -- DEPTH-entry FIFO of gemm_instr_t.
//   clk_i/rst_i : clock, synchronous active-high reset (empties the queue)
//   push_i/din_i: write an entry (ignored when full)
//   pop_i/dout_o: dout_o shows the head; pop_i drops it (ignored when empty)
//   count_o     : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module gemm_instr_fifo
   import fu_gemm_seq_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  gemm_instr_t   din_i,
   input  logic          pop_i,
   output gemm_instr_t   dout_o,
   output logic [CW-1:0] count_o
);

   gemm_instr_t   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign do_push = push_i && (count_q < CW'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Storage needs no reset: count_q gates every read that matters.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fu_gemm_seq.sv
// fu_gemm_seq -- GEMM instruction sequencer.
// Queues GEMM instructions and, per instruction, optionally loads ROWS weight
// rows (skipped when the array already holds rs2 and no reload is forced),
// streams ROWS input rows with their partial-sum register, then offers a
// writeback of rd.
//   CLK, RST                  : clock, synchronous active-high reset
//   in_valid/in_ready + rs*_in, rd_in, new_weight_in : instruction push
//   req_valid/req_ready, req_kind/req_reg/req_psum_reg/req_row : row requests
//   wb_valid/wb_ready, wb_rd  : writeback handshake
//   weight_valid, weight_reg  : weight currently resident in the array
//   busy                      : queue non-empty or sequencer not idle
// REG_W must not exceed GEMM_REG_W_MAX; DEPTH and ROWS are powers of two >= 2.
module fu_gemm_seq
   import fu_gemm_seq_pkg::*;
#(
   parameter  int REG_W = 4,
   parameter  int DEPTH = 4,
   parameter  int ROWS  = 4,
   localparam int RW    = $clog2(ROWS),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             new_weight_in,
   input  logic [REG_W-1:0] rs1_in,
   input  logic [REG_W-1:0] rs2_in,
   input  logic [REG_W-1:0] rs3_in,
   input  logic [REG_W-1:0] rd_in,
   output logic             req_valid,
   input  logic             req_ready,
   output logic             req_kind,
   output logic [REG_W-1:0] req_reg,
   output logic [REG_W-1:0] req_psum_reg,
   output logic [RW-1:0]    req_row,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [REG_W-1:0] wb_rd,
   output logic             weight_valid,
   output logic [REG_W-1:0] weight_reg,
   output logic             busy
);

   gemm_state_t      state_q, state_d;
   logic [RW-1:0]    r_q, r_d;
   gemm_instr_t      cur_q, cur_d;
   logic             wv_q, wv_d;
   logic [REG_W-1:0] wreg_q, wreg_d;

   gemm_instr_t      push_instr, head;
   logic [CW-1:0]    count;
   logic             push, pop;
   logic             last_row;
   logic             unused_cur;

   assign push_instr = '{rs1: gemm_reg_t'(rs1_in), rs2: gemm_reg_t'(rs2_in),
                         rs3: gemm_reg_t'(rs3_in), rd: gemm_reg_t'(rd_in),
                         new_weight: new_weight_in};
   assign push       = in_valid && in_ready;
   assign last_row   = (r_q == RW'(ROWS - 1));
   // High register bits and the consumed reload flag are carried but not read.
   assign unused_cur = ^cur_q;

   gemm_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i  (CLK),
      .rst_i  (RST),
      .push_i (push),
      .din_i  (push_instr),
      .pop_i  (pop),
      .dout_o (head),
      .count_o(count)
   );

   // Status outputs are forced low during reset so they are defined even
   // before the first reset edge has cleared the registers.
   assign in_ready     = !RST && (count < CW'(DEPTH));
   assign busy         = !RST && ((count != '0) || (state_q != IDLE));
   assign weight_valid = !RST && wv_q;
   assign weight_reg   = RST ? '0 : wreg_q;

   always_comb begin
      state_d      = state_q;
      r_d          = r_q;
      cur_d        = cur_q;
      wv_d         = wv_q;
      wreg_d       = wreg_q;
      pop          = 1'b0;
      req_valid    = 1'b0;
      req_kind     = REQ_WEIGHT;
      req_reg      = '0;
      req_psum_reg = '0;
      req_row      = '0;
      wb_valid     = 1'b0;
      wb_rd        = '0;
      unique case (state_q)
         IDLE: begin
            if (count != '0) begin
               pop   = 1'b1;
               cur_d = head;
               if (wv_q && (head.rs2[REG_W-1:0] == wreg_q) && !head.new_weight)
                  state_d = STREAM;
               else
                  state_d = LOAD_W;
            end
         end
         LOAD_W: begin
            req_valid = 1'b1;
            req_kind  = REQ_WEIGHT;
            req_reg   = cur_q.rs2[REG_W-1:0];
            req_row   = r_q;
            if (req_ready) begin
               // r wraps to 0 on the final row, ready for the stream phase.
               r_d = r_q + RW'(1);
               if (last_row) begin
                  wv_d    = 1'b1;
                  wreg_d  = cur_q.rs2[REG_W-1:0];
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            req_valid    = 1'b1;
            req_kind     = REQ_INPUT;
            req_reg      = cur_q.rs1[REG_W-1:0];
            req_psum_reg = cur_q.rs3[REG_W-1:0];
            req_row      = r_q;
            if (req_ready) begin
               r_d = r_q + RW'(1);
               if (last_row) state_d = WB;
            end
         end
         WB: begin
            wb_valid = 1'b1;
            wb_rd    = cur_q.rd[REG_W-1:0];
            if (wb_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (RST) begin
         pop          = 1'b0;
         req_valid    = 1'b0;
         req_kind     = REQ_WEIGHT;
         req_reg      = '0;
         req_psum_reg = '0;
         req_row      = '0;
         wb_valid     = 1'b0;
         wb_rd        = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         r_q     <= '0;
         cur_q   <= '0;
         wv_q    <= 1'b0;
         wreg_q  <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         cur_q   <= cur_d;
         wv_q    <= wv_d;
         wreg_q  <= wreg_d;
      end
   end

endmodule

// File: tb/tb_fu_gemm_seq.sv
// tb_fu_gemm_seq -- self-checking bench for fu_gemm_seq.
// The reference model turns every accepted instruction into the ordered list
// of transfers it must produce (weight rows, input rows, writeback), deciding
// weight reuse from the previously pushed instructions. Every cycle a valid
// request/writeback is compared against the head of that list, so a stalled
// request must keep matching it and a handshake consumes exactly one entry.
module tb_fu_gemm_seq;
   localparam int REG_W = 4;
   localparam int DEPTH = 4;
   localparam int ROWS  = 4;
   localparam int RW    = 2;

   logic             CLK = 1'b0, RST = 1'b1;
   logic             in_valid = 1'b0, new_weight_in = 1'b0;
   logic             req_ready = 1'b0, wb_ready = 1'b0;
   logic [REG_W-1:0] rs1_in = '0, rs2_in = '0, rs3_in = '0, rd_in = '0;
   logic             in_ready, req_valid, req_kind, wb_valid, weight_valid, busy;
   logic [REG_W-1:0] req_reg, req_psum_reg, wb_rd, weight_reg;
   logic [RW-1:0]    req_row;

   fu_gemm_seq #(.REG_W(REG_W), .DEPTH(DEPTH), .ROWS(ROWS)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
      .new_weight_in(new_weight_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
      .rs3_in(rs3_in), .rd_in(rd_in), .req_valid(req_valid),
      .req_ready(req_ready), .req_kind(req_kind), .req_reg(req_reg),
      .req_psum_reg(req_psum_reg), .req_row(req_row), .wb_valid(wb_valid),
      .wb_ready(wb_ready), .wb_rd(wb_rd), .weight_valid(weight_valid),
      .weight_reg(weight_reg), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // kind: 0 weight row, 1 input row, 2 writeback
   typedef struct {int kind; int rg; int ps; int row;} ev_t;
   ev_t exp_q[$];
   bit  mw_valid = 1'b0;
   int  mw_reg   = 0;
   int  n_checks = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   function automatic void model_push(int rs1, int rs2, int rs3, int rd, bit nw);
      if (!(mw_valid && rs2 == mw_reg && !nw)) begin
         for (int r = 0; r < ROWS; r++) exp_q.push_back('{0, rs2, 0, r});
         mw_valid = 1'b1;
         mw_reg   = rs2;
      end
      for (int r = 0; r < ROWS; r++) exp_q.push_back('{1, rs1, rs3, r});
      exp_q.push_back('{2, rd, 0, 0});
   endfunction

   // Check this cycle's outputs, account for handshakes, then advance a clock.
   task automatic cycle();
      ev_t e;
      if (!RST && (req_valid || wb_valid)) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", {30'd0, req_valid, wb_valid}, 0);
         end else begin
            e = exp_q[0];
            chk("valid_exclusive", {31'd0, req_valid & wb_valid}, 0);
            chk("ev_kind", wb_valid ? 2 : {31'd0, req_kind}, e.kind);
            if (wb_valid) begin
               chk("wb_rd", wb_rd, e.rg);
               if (wb_ready) exp_q.delete(0);
            end else begin
               chk("req_reg", req_reg, e.rg);
               chk("req_row", req_row, e.row);
               if (e.kind == 1) chk("req_psum", req_psum_reg, e.ps);
               if (req_ready) exp_q.delete(0);
            end
         end
      end
      if (in_valid && in_ready) model_push(rs1_in, rs2_in, rs3_in, rd_in, new_weight_in);
      @(posedge CLK);
      #1;
   endtask

   task automatic push_one(input int a, input int b, input int c, input int d, input bit nw);
      rs1_in = REG_W'(a); rs2_in = REG_W'(b); rs3_in = REG_W'(c); rd_in = REG_W'(d);
      new_weight_in = nw;
      chk("in_ready_push", in_ready, 1);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
   endtask

   // Returns the number of cycles spent before wb_valid appeared.
   task automatic wait_wb(input int budget, output int n);
      n = 0;
      while (!wb_valid && n < budget) begin cycle(); n++; end
      chk("wb_timeout", wb_valid, 1);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin cycle(); n++; end
      chk("drain_model_empty", exp_q.size(), 0);
      chk("drain_idle", busy, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int seen_wb;
      RST = 1'b1; req_ready = 1'b1; wb_ready = 1'b1;
      repeat (3) cycle();
      chk("rst_req_valid", req_valid, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_weight_valid", weight_valid, 0);
      chk("rst_weight_reg", weight_reg, 0);
      chk("rst_req_reg", req_reg, 0);
      chk("rst_wb_rd", wb_rd, 0);
      RST = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // Cold start: weight load then stream; writeback 2*ROWS+2 after push.
      push_one(1, 2, 3, 4, 0);
      chk("busy_run", busy, 1);
      wait_wb(40, n);
      chk("lat_load", n + 1, 2 * ROWS + 2);
      cycle();
      chk("weight_valid_t1", weight_valid, 1);
      chk("weight_reg_t1", weight_reg, 2);

      // Same weight register: no load phase, writeback ROWS+2 after push.
      push_one(2, 2, 3, 4, 0);
      wait_wb(40, n);
      chk("lat_reuse", n + 1, ROWS + 2);
      cycle();

      // Forced reload of the same weight register.
      push_one(2, 2, 3, 4, 1);
      wait_wb(40, n);
      chk("lat_reload", n + 1, 2 * ROWS + 2);
      cycle();
      drain(20);

      // Requests stalled: one instruction moves into execution, the next four
      // fill the queue, after which in_ready must be low.
      req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rs1_in = REG_W'(i); rs2_in = 4'd5; rs3_in = REG_W'(i + 1); rd_in = REG_W'(i + 8);
         new_weight_in = 1'b0;
         chk("in_ready_fill", in_ready, 1);
         in_valid = 1'b1;
         cycle();
      end
      rs1_in = 4'd15; rd_in = 4'd15;
      chk("in_ready_full", in_ready, 0);
      cycle();
      in_valid = 1'b0;
      repeat (4) cycle();
      chk("in_ready_still_full", in_ready, 0);
      req_ready = 1'b1;
      drain(300);

      // Random traffic with random back-pressure on both outputs.
      for (int i = 0; i < 600; i++) begin
         req_ready     = ($urandom_range(0, 2) != 0);
         wb_ready      = ($urandom_range(0, 1) != 0);
         in_valid      = ($urandom_range(0, 3) == 0);
         rs1_in        = REG_W'($urandom_range(0, 15));
         rs2_in        = REG_W'($urandom_range(2, 3));
         rs3_in        = REG_W'($urandom_range(0, 15));
         rd_in         = REG_W'($urandom_range(0, 15));
         new_weight_in = ($urandom_range(0, 3) == 0);
         cycle();
      end
      in_valid = 1'b0; req_ready = 1'b1; wb_ready = 1'b1;
      drain(1000);

      // Reset in the middle of the stream phase.
      push_one(6, 7, 8, 9, 1);
      n = 0;
      while (!(req_valid && req_kind && req_row == 2) && n < 50) begin cycle(); n++; end
      chk("reach_stream_row2", {req_valid, req_kind, req_row}, 4'b1110);
      RST = 1'b1;
      #1;
      chk("midrst_req_valid", req_valid, 0);
      cycle();
      exp_q.delete();
      mw_valid = 1'b0;
      RST = 1'b0;
      #1;
      chk("midrst_req_valid_after", req_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_weight_valid", weight_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      seen_wb = 0;
      for (int i = 0; i < 20; i++) begin
         if (wb_valid) seen_wb++;
         cycle();
      end
      chk("midrst_no_wb", seen_wb, 0);

      // Weight was invalidated: same rs2 must be reloaded.
      push_one(1, 7, 2, 3, 0);
      wait_wb(40, n);
      chk("lat_after_rst", n + 1, 2 * ROWS + 2);
      drain(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
